// File: rtl/dp_dmi_pkg.sv
// Shared types and defaults for the DMI transaction controller.
package dp_dmi_pkg;

  localparam int unsigned DMI_ABITS = 7;
  localparam int unsigned DMI_DBITS = 32;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSV   = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    ST_OK     = 2'd0,
    ST_FAILED = 2'd2,
    ST_BUSY   = 2'd3
  } dmi_status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } dmi_state_e;

  function automatic logic op_is_access(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/dp_dmi_timeout.sv
// Loadable saturating down-counter; expire_o pulses on every enabled cycle at zero.
module dp_dmi_timeout #(
  parameter int unsigned TO_CYCLES = 1023
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  // Loading TO_CYCLES-1 makes the TO_CYCLES-th enabled cycle the expiring one.
  localparam logic [CW-1:0] LOAD_VAL = (TO_CYCLES == 0) ? '0 : CW'(TO_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    expire_o = (TO_CYCLES != 0) && en_i && !load_i && (cnt_q == '0);
  end

endmodule

// File: rtl/dp_dmi_ctrl.sv
// DMI transaction sequencer: one request per DR update, sticky status, capture data/status.
module dp_dmi_ctrl
  import dp_dmi_pkg::*;
#(
  parameter int unsigned ABITS     = DMI_ABITS,
  parameter int unsigned DBITS     = DMI_DBITS,
  parameter int unsigned TO_CYCLES = 1023
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic             upd_dmi,
  input  logic             cap_dmi,
  input  logic [ABITS-1:0] dmi_addr,
  input  logic [DBITS-1:0] dmi_data,
  input  logic [1:0]       dmi_op,
  input  logic             dmireset,
  input  logic             dmihardreset,
  output logic [DBITS-1:0] cap_data,
  output logic [1:0]       cap_op,
  output logic             dmi_busy,
  output logic [1:0]       dmistat,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [ABITS-1:0] req_addr,
  output logic [DBITS-1:0] req_data,
  output logic [1:0]       req_op,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [DBITS-1:0] rsp_data,
  input  logic [1:0]       rsp_op
);

  dmi_state_e       state_q, state_d;
  logic [ABITS-1:0] req_addr_q, req_addr_d;
  logic [DBITS-1:0] req_data_q, req_data_d;
  logic [1:0]       req_op_q, req_op_d;
  logic [DBITS-1:0] cap_data_q, cap_data_d;
  dmi_status_e      sticky_q, sticky_d;
  dmi_status_e      cap_op_q, cap_op_d;

  logic busy;
  logic launch;
  logic to_expire;
  logic soft_rst;

  always_comb begin
    soft_rst = ireset | dmihardreset;
    busy     = (state_q != S_IDLE);
    launch   = (state_q == S_IDLE) && upd_dmi && op_is_access(dmi_op) && (sticky_q == ST_OK);
  end

  dp_dmi_timeout #(
    .TO_CYCLES(TO_CYCLES)
  ) u_timeout (
    .clk_i   (iclk),
    .rst_i   (soft_rst),
    .load_i  (launch),
    .en_i    (busy),
    .expire_o(to_expire)
  );

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_op_d   = req_op_q;
    cap_data_d = cap_data_q;
    sticky_d   = sticky_q;

    if (busy && (upd_dmi || cap_dmi) && (sticky_q == ST_OK)) begin
      sticky_d = ST_BUSY;
    end

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d    = S_REQ;
          req_addr_d = dmi_addr;
          req_data_d = dmi_data;
          req_op_d   = dmi_op;
        end
      end
      S_REQ: begin
        // A completed handshake takes priority over a coincident timeout.
        if (req_ready) begin
          state_d = S_RSP;
        end else if (to_expire) begin
          state_d  = S_IDLE;
          sticky_d = ST_FAILED;
        end
      end
      S_RSP: begin
        if (rsp_valid) begin
          state_d = S_IDLE;
          if (req_op_q == OP_READ) begin
            cap_data_d = rsp_data;
          end
          if (rsp_op != 2'b00) begin
            sticky_d = ST_FAILED;
          end
        end else if (to_expire) begin
          state_d  = S_IDLE;
          sticky_d = ST_FAILED;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (dmireset) begin
      sticky_d = ST_OK;
    end

    cap_op_d = (busy && cap_dmi) ? ST_BUSY : sticky_d;
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_op_q   <= '0;
      cap_data_q <= '0;
      sticky_q   <= ST_OK;
      cap_op_q   <= ST_OK;
    end else if (dmihardreset) begin
      state_q    <= S_IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_op_q   <= '0;
      sticky_q   <= ST_OK;
      cap_op_q   <= ST_OK;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_op_q   <= req_op_d;
      cap_data_q <= cap_data_d;
      sticky_q   <= sticky_d;
      cap_op_q   <= cap_op_d;
    end
  end

  always_comb begin
    req_valid = (state_q == S_REQ);
    rsp_ready = (state_q == S_RSP);
    dmi_busy  = busy;
    dmistat   = sticky_q;
    cap_op    = cap_op_q;
    cap_data  = cap_data_q;
    req_addr  = req_addr_q;
    req_data  = req_data_q;
    req_op    = req_op_q;
  end

endmodule

// File: tb/tb_dp_dmi_ctrl.sv
// Bench for dp_dmi_ctrl: directed scenarios then random traffic against a transaction-level model.
module tb_dp_dmi_ctrl;

  localparam int unsigned AB = 7;
  localparam int unsigned DB = 32;
  localparam int unsigned TO = 8;

  logic          iclk = 1'b0;
  logic          ireset, upd_dmi, cap_dmi, dmireset, dmihardreset;
  logic [AB-1:0] dmi_addr;
  logic [DB-1:0] dmi_data, rsp_data;
  logic [1:0]    dmi_op, rsp_op;
  logic          req_ready, rsp_valid;
  logic [DB-1:0] cap_data, req_data;
  logic [1:0]    cap_op, dmistat, req_op;
  logic          dmi_busy, req_valid, rsp_ready;
  logic [AB-1:0] req_addr;

  always #5 iclk = ~iclk;

  dp_dmi_ctrl #(
    .ABITS    (AB),
    .DBITS    (DB),
    .TO_CYCLES(TO)
  ) dut (
    .iclk        (iclk),
    .ireset      (ireset),
    .upd_dmi     (upd_dmi),
    .cap_dmi     (cap_dmi),
    .dmi_addr    (dmi_addr),
    .dmi_data    (dmi_data),
    .dmi_op      (dmi_op),
    .dmireset    (dmireset),
    .dmihardreset(dmihardreset),
    .cap_data    (cap_data),
    .cap_op      (cap_op),
    .dmi_busy    (dmi_busy),
    .dmistat     (dmistat),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_op      (req_op),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_op      (rsp_op)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: one outstanding transaction, described by its phase and age.
  bit            m_busy     = 0;
  bit            m_accepted = 0;
  int unsigned   m_age      = 0;
  logic [AB-1:0] m_addr     = '0;
  logic [DB-1:0] m_data     = '0;
  logic [1:0]    m_op       = '0;
  logic [1:0]    m_sticky   = '0;
  logic [1:0]    m_cap_op   = '0;
  logic [DB-1:0] m_cap_data = '0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_accepted = 0; m_age = 0;
    m_addr = '0; m_data = '0; m_op = '0;
    m_sticky = '0; m_cap_op = '0;
  endtask

  task automatic model_tick();
    logic [1:0] nst;
    bit         was_busy;
    if (ireset) begin
      model_clear();
      m_cap_data = '0;
      return;
    end
    if (dmihardreset) begin
      model_clear();
      return;
    end
    was_busy = m_busy;
    nst      = m_sticky;
    if (was_busy) begin
      if ((upd_dmi || cap_dmi) && m_sticky == 2'd0) nst = 2'd3;
      m_age++;
      if (!m_accepted) begin
        if (req_ready) m_accepted = 1;
        else if (m_age >= TO) begin m_busy = 0; nst = 2'd2; end
      end else begin
        if (rsp_valid) begin
          m_busy = 0;
          if (m_op == 2'd1) m_cap_data = rsp_data;
          if (rsp_op != 2'd0) nst = 2'd2;
        end else if (m_age >= TO) begin
          m_busy = 0; nst = 2'd2;
        end
      end
    end else if (upd_dmi && (dmi_op == 2'd1 || dmi_op == 2'd2) && m_sticky == 2'd0) begin
      m_busy = 1; m_accepted = 0; m_age = 0;
      m_addr = dmi_addr; m_data = dmi_data; m_op = dmi_op;
    end
    if (dmireset) nst = 2'd0;
    m_cap_op = (cap_dmi && was_busy) ? 2'd3 : nst;
    m_sticky = nst;
  endtask

  task automatic check_all();
    check_val("req_valid", req_valid, m_busy && !m_accepted);
    check_val("rsp_ready", rsp_ready, m_busy && m_accepted);
    check_val("dmi_busy",  dmi_busy,  m_busy);
    check_val("dmistat",   dmistat,   m_sticky);
    check_val("cap_op",    cap_op,    m_cap_op);
    check_val("cap_data",  cap_data,  m_cap_data);
    check_val("req_addr",  req_addr,  m_addr);
    check_val("req_data",  req_data,  m_data);
    check_val("req_op",    req_op,    m_op);
  endtask

  task automatic step();
    @(posedge iclk);
    model_tick();
    @(negedge iclk);
    check_all();
  endtask

  task automatic pulses_low();
    ireset = 0; upd_dmi = 0; cap_dmi = 0; dmireset = 0; dmihardreset = 0;
  endtask

  task automatic upd(input logic [1:0] op, input logic [AB-1:0] a, input logic [DB-1:0] d);
    upd_dmi = 1; dmi_op = op; dmi_addr = a; dmi_data = d;
    step();
    upd_dmi = 0;
  endtask

  task automatic respond(input logic [1:0] rop, input logic [DB-1:0] rd);
    rsp_valid = 1; rsp_op = rop; rsp_data = rd;
    step();
    rsp_valid = 0; rsp_op = 2'd0;
  endtask

  initial begin
    int unsigned hi;
    pulses_low();
    dmi_addr = '0; dmi_data = '0; dmi_op = '0;
    req_ready = 0; rsp_valid = 0; rsp_data = '0; rsp_op = '0;
    ireset = 1;
    step();
    step();
    ireset = 0;
    check_val("rst_busy", dmi_busy, 1'b0);
    check_val("rst_cap_data", cap_data, 32'h0);

    // Write with immediate accept, OK response.
    req_ready = 1;
    upd(2'd2, 7'h12, 32'hDEADBEEF);
    check_val("w_valid", req_valid, 1'b1);
    check_val("w_data", req_data, 32'hDEADBEEF);
    step();
    check_val("w_vdrop", req_valid, 1'b0);
    req_ready = 0;
    respond(2'd0, 32'h0);
    check_val("w_done_busy", dmi_busy, 1'b0);
    check_val("w_cap_op", cap_op, 2'd0);

    // Read with 5 stalled cycles before accept.
    upd(2'd1, 7'h11, 32'h0);
    for (int i = 0; i < 6; i++) begin
      check_val("r_stable_addr", req_addr, 7'h11);
      check_val("r_stable_valid", req_valid, 1'b1);
      req_ready = (i == 5);
      step();
    end
    req_ready = 0;
    check_val("r_acc", rsp_ready, 1'b1);
    respond(2'd0, 32'hCAFEF00D);
    check_val("r_cap_data", cap_data, 32'hCAFEF00D);

    // Update while busy: dropped, busy status sticks until dmireset.
    req_ready = 1;
    upd(2'd1, 7'h05, 32'h0);
    step();
    req_ready = 0;
    upd(2'd2, 7'h06, 32'h12345678);
    check_val("busy_stat", dmistat, 2'd3);
    check_val("busy_noreq", req_valid, 1'b0);
    respond(2'd0, 32'h0BADF00D);
    upd(2'd2, 7'h07, 32'h1);
    check_val("sticky_ignore", dmi_busy, 1'b0);
    dmireset = 1; step(); dmireset = 0;
    check_val("dmireset_clr", dmistat, 2'd0);

    // Failed write response, then recovery.
    req_ready = 1;
    upd(2'd2, 7'h20, 32'hA5A5A5A5);
    step();
    req_ready = 0;
    respond(2'd2, 32'h0);
    check_val("fail_stat", dmistat, 2'd2);
    check_val("fail_cap_op", cap_op, 2'd2);
    dmireset = 1; step(); dmireset = 0;
    req_ready = 1;
    upd(2'd1, 7'h21, 32'h0);
    step();
    req_ready = 0;
    respond(2'd0, 32'h600DCAFE);
    check_val("recov_cap_op", cap_op, 2'd0);
    check_val("recov_data", cap_data, 32'h600DCAFE);

    // Timeout with req_ready never asserted.
    upd(2'd2, 7'h30, 32'h55);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      if (req_valid) hi++;
      step();
    end
    check_val("to_valid_cycles", hi, TO);
    check_val("to_stat", dmistat, 2'd2);
    check_val("to_idle", dmi_busy, 1'b0);
    dmireset = 1; step(); dmireset = 0;

    // dmihardreset mid-response, ireset mid-request.
    req_ready = 1;
    upd(2'd1, 7'h40, 32'h0);
    step();
    req_ready = 0;
    dmihardreset = 1; step(); dmihardreset = 0;
    check_val("hr_busy", dmi_busy, 1'b0);
    check_val("hr_addr", req_addr, 7'h0);
    check_val("hr_cap_kept", cap_data, 32'h600DCAFE);
    upd(2'd2, 7'h33, 32'h77);
    check_val("hr_new_req", req_valid, 1'b1);
    ireset = 1; step(); ireset = 0;
    check_val("ir_valid", req_valid, 1'b0);
    check_val("ir_cap_data", cap_data, 32'h0);
    req_ready = 1;
    upd(2'd2, 7'h34, 32'h88);
    check_val("ir_new_req", req_valid, 1'b1);
    step();
    req_ready = 0;
    respond(2'd0, 32'h0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      upd_dmi      = ($urandom_range(5) == 0);
      dmi_op       = 2'($urandom_range(3));
      dmi_addr     = 7'($urandom_range(127));
      dmi_data     = $urandom;
      cap_dmi      = ($urandom_range(7) == 0);
      dmireset     = ($urandom_range(11) == 0);
      dmihardreset = ($urandom_range(99) == 0);
      ireset       = ($urandom_range(499) == 0);
      req_ready    = ($urandom_range(3) == 0);
      rsp_valid    = ($urandom_range(3) == 0);
      rsp_data     = $urandom;
      r            = $urandom_range(3);
      rsp_op       = (r < 2) ? 2'd0 : 2'(r);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
